// File: rtl/pc_seq_if.sv
// Core/shifter-facing bundle for pc_sequencer.
// The slave modport is the sequencer's view; the master modport is the core and jump-target-shifter view.
interface pc_seq_if;
    logic        step;
    logic        is_j;
    logic        is_jr;
    logic        is_b;
    logic        b_taken;
    logic [25:0] jidx;
    logic [15:0] boff;
    logic [31:0] jr_tgt;
    logic [25:0] shft_in;
    logic [27:0] shft_out;
    logic [31:0] pc;
    logic        busy;
    logic        redirect;

    modport slave (
        input  step, is_j, is_jr, is_b, b_taken, jidx, boff, jr_tgt, shft_out,
        output shft_in, pc, busy, redirect
    );

    modport master (
        output step, is_j, is_jr, is_b, b_taken, jidx, boff, jr_tgt, shft_out,
        input  shft_in, pc, busy, redirect
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequential steps, branches, JR, and J via an external 1-cycle shifter.
// Define PC_SEQ_DELAY_SLOT_EN to defer control-flow targets by one step (MIPS branch delay slot).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic     clk,
    input logic     rst_n,
    pc_seq_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        JISSUE = 2'd1,
        JWAIT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic        [31:0] pc_q, pc_d;
    logic        [31:0] pc4_q, pc4_d;
    logic        [25:0] shft_in_q, shft_in_d;
    logic               redirect_q, redirect_d;

    logic        [31:0] pc_plus4;
    logic signed [31:0] br_off;
    logic        [31:0] br_tgt;
    logic        [31:0] jr_dest;
    logic        [31:0] j_dest;
    logic               accept;
    logic               ctl_ok;
    logic               req_jr;
    logic               req_j;
    logic               req_b;

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic        [31:0] pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               slot_step;
`endif

    // Request decode: only RUN accepts a step, priority JR > J > B.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_off   = {{14{bus.boff[15]}}, bus.boff, 2'b00};
        br_tgt   = pc_plus4 + $unsigned(br_off);
        jr_dest  = bus.jr_tgt & 32'hFFFF_FFFC;
        j_dest   = (pc4_q & 32'hF000_0000) | {4'h0, bus.shft_out};
        accept   = bus.step && (state_q == RUN);
`ifdef PC_SEQ_DELAY_SLOT_EN
        slot_step = accept && pend_vld_q;
        ctl_ok    = !pend_vld_q;
`else
        ctl_ok    = 1'b1;
`endif
        req_jr = accept && ctl_ok && bus.is_jr;
        req_j  = accept && ctl_ok && bus.is_j && !bus.is_jr;
        req_b  = accept && ctl_ok && bus.is_b && bus.b_taken && !bus.is_j && !bus.is_jr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pc4_q      <= 32'd0;
            shft_in_q  <= 26'd0;
            redirect_q <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
            pend_q     <= 32'd0;
            pend_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            shft_in_q  <= shft_in_d;
            redirect_q <= redirect_d;
`ifdef PC_SEQ_DELAY_SLOT_EN
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (req_j) state_d = JISSUE;
            JISSUE:  state_d = JWAIT;
            JWAIT:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        shft_in_d  = shft_in_q;
        redirect_d = 1'b0;
        if (req_j) begin
            pc4_d     = pc_plus4;
            shft_in_d = bus.jidx;
        end
`ifdef PC_SEQ_DELAY_SLOT_EN
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        // Control targets park in pend_q while the delay-slot instruction executes.
        if (slot_step) begin
            pc_d       = pend_q;
            pend_vld_d = 1'b0;
            redirect_d = 1'b1;
        end else if (req_jr) begin
            pc_d       = pc_plus4;
            pend_d     = jr_dest;
            pend_vld_d = 1'b1;
        end else if (req_b) begin
            pc_d       = pc_plus4;
            pend_d     = br_tgt;
            pend_vld_d = 1'b1;
        end else if (accept && !req_j) begin
            pc_d = pc_plus4;
        end
        if (state_q == JWAIT) begin
            pc_d       = pc4_q;
            pend_d     = j_dest;
            pend_vld_d = 1'b1;
        end
`else
        if (req_jr) begin
            pc_d       = jr_dest;
            redirect_d = 1'b1;
        end else if (req_b) begin
            pc_d       = br_tgt;
            redirect_d = 1'b1;
        end else if (accept && !req_j) begin
            pc_d = pc_plus4;
        end
        if (state_q == JWAIT) begin
            pc_d       = j_dest;
            redirect_d = 1'b1;
        end
`endif
    end

    assign bus.pc       = pc_q;
    assign bus.shft_in  = shft_in_q;
    assign bus.redirect = redirect_q;
    assign bus.busy     = (state_q != RUN);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a model of the external jump-target shifter.
// Honours PC_SEQ_DELAY_SLOT_EN when defined for the build.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_pv;

    pc_seq_if bus ();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // External shifter: registered {index, 2'b00}.
    initial bus.shft_out = 28'd0;
    always @(posedge clk) bus.shft_out <= {bus.shft_in, 2'b00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, jr, j, b, tk, input logic [25:0] ji,
                         input logic [15:0] bo, input logic [31:0] jt);
        bus.step = st; bus.is_jr = jr; bus.is_j = j; bus.is_b = b; bus.b_taken = tk;
        bus.jidx = ji; bus.boff = bo; bus.jr_tgt = jt;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_pc = RST_PC;
        m_pv = 0;
        m_pend = '0;
    endtask

    // Architectural effect of one accepted step, from the instruction-level rules.
    task automatic ref_step(input bit jr, j, b, tk, input logic [25:0] ji, input logic [15:0] bo,
                            input logic [31:0] jt, output logic [31:0] npc, output bit nredir,
                            output bit jump);
        logic [31:0] seq, tgt;
        bit ctrl;
        seq = m_pc + 32'd4;
        ctrl = 1;
        jump = 0;
        if (jr) tgt = jt & ~32'd3;
        else if (j) begin tgt = {seq[31:28], ji, 2'b00}; jump = 1; end
        else if (b && tk) tgt = 32'(longint'(seq) + longint'($signed(bo)) * 4);
        else begin tgt = seq; ctrl = 0; end
`ifdef PC_SEQ_DELAY_SLOT_EN
        if (m_pv) begin npc = m_pend; nredir = 1; m_pv = 0; jump = 0; end
        else if (ctrl) begin npc = seq; nredir = 0; m_pend = tgt; m_pv = 1; end
        else begin npc = seq; nredir = 0; end
`else
        npc = tgt;
        nredir = ctrl;
`endif
        m_pc = npc;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        rst_n = 1'b0;
        tick();
        total++; if (bus.pc !== RST_PC) begin bad++; $display("FAIL rst_pc got=%h exp=%h", bus.pc, RST_PC); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%b exp=0", bus.redirect); end
        total++; if (bus.shft_in !== 26'd0) begin bad++; $display("FAIL rst_shft_in got=%h exp=0", bus.shft_in); end
        rst_n = 1'b1;
        exp_pc = RST_PC;
        bus.step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL plain_pc%0d got=%h exp=%h", i, bus.pc, exp_pc); end
            total++; if (bus.busy !== 1'b0 || bus.redirect !== 1'b0) begin bad++; $display("FAIL plain_flags%0d got=%b%b exp=00", i, bus.busy, bus.redirect); end
        end
        bus.step = 1'b0;
    endtask

`ifndef PC_SEQ_DELAY_SLOT_EN
    task automatic test_jump();
        drive(1, 1, 0, 0, 0, '0, '0, 32'h1000_0008);
        tick();
        total++; if (bus.pc !== 32'h1000_0008) begin bad++; $display("FAIL j_setup_pc got=%h exp=10000008", bus.pc); end
        drive(1, 0, 1, 0, 0, 26'h0000040, '0, '0);
        tick();
        total++; if (bus.shft_in !== 26'h40) begin bad++; $display("FAIL j_shft_in got=%h exp=40", bus.shft_in); end
        total++; if (bus.busy !== 1'b1 || bus.redirect !== 1'b0) begin bad++; $display("FAIL j_e0_flags got=%b%b exp=10", bus.busy, bus.redirect); end
        tick();
        total++; if (bus.busy !== 1'b1 || bus.pc !== 32'h1000_0008) begin bad++; $display("FAIL j_e1 got busy=%b pc=%h exp busy=1 pc=10000008", bus.busy, bus.pc); end
        tick();
        total++; if (bus.pc !== 32'h1000_0100) begin bad++; $display("FAIL j_target got=%h exp=10000100", bus.pc); end
        total++; if (bus.busy !== 1'b0 || bus.redirect !== 1'b1) begin bad++; $display("FAIL j_e2_flags got=%b%b exp=01", bus.busy, bus.redirect); end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        tick();
        total++; if (bus.pc !== 32'h1000_0100 || bus.redirect !== 1'b0) begin bad++; $display("FAIL j_after got pc=%h red=%b exp pc=10000100 red=0", bus.pc, bus.redirect); end
    endtask

    task automatic test_branch();
        drive(1, 1, 0, 0, 0, '0, '0, 32'h0000_0100);
        tick();
        drive(1, 0, 0, 1, 1, '0, 16'hFFFE, '0);
        tick();
        total++; if (bus.pc !== 32'h0000_00FC || bus.redirect !== 1'b1) begin bad++; $display("FAIL b_taken got pc=%h red=%b exp pc=000000fc red=1", bus.pc, bus.redirect); end
        drive(1, 1, 0, 0, 0, '0, '0, 32'h0000_0100);
        tick();
        drive(1, 0, 0, 1, 0, '0, 16'hFFFE, '0);
        tick();
        total++; if (bus.pc !== 32'h0000_0104 || bus.redirect !== 1'b0) begin bad++; $display("FAIL b_not_taken got pc=%h red=%b exp pc=00000104 red=0", bus.pc, bus.redirect); end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_jr_priority();
        drive(1, 1, 1, 1, 1, 26'h3FF_FFFF, 16'h0010, 32'h0000_2003);
        tick();
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        total++; if (bus.pc !== 32'h0000_2000) begin bad++; $display("FAIL jr_pc got=%h exp=00002000", bus.pc); end
        total++; if (bus.shft_in !== 26'h40 || bus.busy !== 1'b0) begin bad++; $display("FAIL jr_no_shift got shft_in=%h busy=%b exp shft_in=40 busy=0", bus.shft_in, bus.busy); end
        total++; if (bus.redirect !== 1'b1) begin bad++; $display("FAIL jr_redirect got=%b exp=1", bus.redirect); end
    endtask

    task automatic test_reset_mid_jump();
        drive(1, 0, 1, 0, 0, 26'h0000123, '0, '0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (bus.pc !== RST_PC || bus.busy !== 1'b0) begin bad++; $display("FAIL midj_reset got pc=%h busy=%b exp pc=%h busy=0", bus.pc, bus.busy, RST_PC); end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.pc !== RST_PC || bus.redirect !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midj_after%0d got pc=%h red=%b busy=%b exp pc=%h red=0 busy=0", i, bus.pc, bus.redirect, bus.busy, RST_PC); end
        end
    endtask
`else
    task automatic test_delay_slot();
        do_reset();
        drive(1, 1, 0, 0, 0, '0, '0, 32'h0000_0100);
        tick();
        total++; if (bus.pc !== RST_PC + 32'd4 || bus.redirect !== 1'b0) begin bad++; $display("FAIL ds_jr_slot got pc=%h red=%b exp pc=%h red=0", bus.pc, bus.redirect, RST_PC + 32'd4); end
        drive(1, 0, 0, 0, 0, '0, '0, '0);
        tick();
        total++; if (bus.pc !== 32'h0000_0100 || bus.redirect !== 1'b1) begin bad++; $display("FAIL ds_jr_load got pc=%h red=%b exp pc=00000100 red=1", bus.pc, bus.redirect); end
        drive(1, 0, 0, 1, 1, '0, 16'h0004, '0);
        tick();
        total++; if (bus.pc !== 32'h0000_0104 || bus.redirect !== 1'b0) begin bad++; $display("FAIL ds_b_slot got pc=%h red=%b exp pc=00000104 red=0", bus.pc, bus.redirect); end
        drive(1, 1, 0, 0, 0, '0, '0, 32'h0000_5000);
        tick();
        total++; if (bus.pc !== 32'h0000_0114 || bus.redirect !== 1'b1) begin bad++; $display("FAIL ds_b_load got pc=%h red=%b exp pc=00000114 red=1", bus.pc, bus.redirect); end
        drive(1, 0, 0, 0, 0, '0, '0, '0);
        tick();
        total++; if (bus.pc !== 32'h0000_0118 || bus.redirect !== 1'b0) begin bad++; $display("FAIL ds_jr_ignored got pc=%h red=%b exp pc=00000118 red=0", bus.pc, bus.redirect); end
        drive(0, 0, 0, 0, 0, '0, '0, '0);
    endtask
`endif

    task automatic test_random();
        logic [31:0] npc, jt;
        logic [25:0] ji;
        logic [15:0] bo;
        bit jr, j, b, tk, nred, jump;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            jr = ($urandom_range(0, 5) == 0);
            j  = ($urandom_range(0, 4) == 0);
            b  = $urandom_range(0, 1);
            tk = $urandom_range(0, 1);
            ji = 26'($urandom);
            bo = 16'($urandom);
            jt = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                drive(0, jr, j, b, tk, ji, bo, jt);
                tick();
                total++; if (bus.pc !== m_pc || bus.redirect !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rnd_idle%0d got pc=%h red=%b busy=%b exp pc=%h red=0 busy=0", n, bus.pc, bus.redirect, bus.busy, m_pc); end
            end else begin
                drive(1, jr, j, b, tk, ji, bo, jt);
                tick();
                ref_step(jr, j, b, tk, ji, bo, jt, npc, nred, jump);
                if (jump) begin
                    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rnd_jbusy%0d got=%b exp=1", n, bus.busy); end
                    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 26'($urandom), 16'($urandom), $urandom);
                    tick();
                    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rnd_jwait%0d got=%b exp=1", n, bus.busy); end
                    tick();
                end
                drive(0, 0, 0, 0, 0, '0, '0, '0);
                total++; if (bus.pc !== npc || bus.redirect !== nred || bus.busy !== 1'b0) begin bad++; $display("FAIL rnd_step%0d got pc=%h red=%b busy=%b exp pc=%h red=%b busy=0", n, bus.pc, bus.redirect, bus.busy, npc, nred); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        test_reset();
`ifndef PC_SEQ_DELAY_SLOT_EN
        test_jump();
        test_branch();
        test_jr_priority();
        test_reset_mid_jump();
`else
        test_delay_slot();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
